// File: rtl/eth_pkg.sv
// Shared types and constants for the UDP receive path.
package eth_pkg;

  localparam int unsigned MAX_UDP_PAYLOAD = 1472;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned CNT_W           = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  // Saturating increment for the frame statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Byte-wide simple dual-port RAM, one write port and one registered read port.
module sdp_ram
  import eth_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when rd_en is low, which gives the stall hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_rx_buffer_ctrl.sv
// UDP payload buffer: speculative frame writes with commit/rollback, length FIFO,
// and a streaming read side with valid/ready handshake.
module udp_rx_buffer_ctrl
  import eth_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned LEN_DEPTH = 4,
  parameter int unsigned MAX_FRAME = MAX_UDP_PAYLOAD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_abort,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  frames_ok,
  output logic [CNT_W-1:0]  frames_dropped,
  output logic [ADDR_W:0]   buf_level
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned LEN_W = $clog2(MAX_FRAME + 1);
  localparam int unsigned LQ_AW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int unsigned LQ_CW = $clog2(LEN_DEPTH + 1);
  localparam int unsigned RAM_BYTES = 1 << ADDR_W;

  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt, commit_ptr, commit_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [LEN_W-1:0] frame_len, frame_len_nxt, remaining, remaining_nxt;
  logic             drop, drop_nxt;
  logic [CNT_W-1:0] ok_nxt, dropped_nxt;
  logic             ram_full, len_max, byte_drop;
  logic             ram_we, ram_re;
  logic [ADDR_W-1:0] ram_ra;

  logic [LEN_W-1:0] lq_mem [LEN_DEPTH];
  logic [LQ_AW-1:0] lq_wr_idx, lq_rd_idx;
  logic [LQ_CW-1:0] lq_count;
  logic             lq_push, lq_pop, lq_full, lq_empty, in_flight;
  logic [LEN_W-1:0] lq_head;

  rd_state_t state, state_nxt;
  logic      out_valid_nxt, out_last_nxt;

  function automatic logic [LQ_AW-1:0] lq_next(input logic [LQ_AW-1:0] idx);
    return (idx == LQ_AW'(LEN_DEPTH - 1)) ? '0 : idx + LQ_AW'(1);
  endfunction

  sdp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (in_data),
    .rd_en   (ram_re),
    .rd_addr (ram_ra),
    .rd_data (out_data)
  );

  assign ram_full   = (wr_ptr - rd_ptr) == PTR_W'(RAM_BYTES);
  assign len_max    = frame_len == LEN_W'(MAX_FRAME);
  assign byte_drop  = drop | ram_full | len_max;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign lq_empty   = lq_count == '0;
  assign lq_head    = lq_mem[lq_rd_idx];
  assign in_flight  = state != RD_IDLE;
  // The frame being streamed still holds its slot, so LEN_DEPTH bounds all unread frames.
  assign lq_full    = (lq_count == LQ_CW'(LEN_DEPTH)) ||
                      (in_flight && lq_count == LQ_CW'(LEN_DEPTH - 1));

  // Write side: speculative byte writes, commit or rollback at frame end.
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    frame_len_nxt  = frame_len;
    drop_nxt       = drop;
    ok_nxt         = frames_ok;
    dropped_nxt    = frames_dropped;
    ram_we         = 1'b0;
    lq_push        = 1'b0;
    if (in_abort) begin
      wr_ptr_nxt    = commit_ptr;
      frame_len_nxt = '0;
      drop_nxt      = 1'b0;
      if (frame_len != '0) dropped_nxt = sat_inc(frames_dropped);
    end else if (in_valid) begin
      if (!byte_drop) begin
        ram_we        = 1'b1;
        wr_ptr_nxt    = wr_ptr + PTR_W'(1);
        frame_len_nxt = frame_len + LEN_W'(1);
      end else begin
        drop_nxt = 1'b1;
      end
      if (in_last) begin
        frame_len_nxt = '0;
        drop_nxt      = 1'b0;
        if (!byte_drop && !lq_full) begin
          lq_push        = 1'b1;
          commit_ptr_nxt = wr_ptr + PTR_W'(1);
          ok_nxt         = sat_inc(frames_ok);
        end else begin
          wr_ptr_nxt  = commit_ptr;
          dropped_nxt = sat_inc(frames_dropped);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      frame_len      <= '0;
      drop           <= 1'b0;
      frames_ok      <= '0;
      frames_dropped <= '0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      commit_ptr     <= commit_ptr_nxt;
      frame_len      <= frame_len_nxt;
      drop           <= drop_nxt;
      frames_ok      <= ok_nxt;
      frames_dropped <= dropped_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (lq_push) lq_mem[lq_wr_idx] <= frame_len + LEN_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lq_wr_idx <= '0;
      lq_rd_idx <= '0;
      lq_count  <= '0;
    end else begin
      if (lq_push) lq_wr_idx <= lq_next(lq_wr_idx);
      if (lq_pop)  lq_rd_idx <= lq_next(lq_rd_idx);
      case ({lq_push, lq_pop})
        2'b10:   lq_count <= lq_count + LQ_CW'(1);
        2'b01:   lq_count <= lq_count - LQ_CW'(1);
        default: lq_count <= lq_count;
      endcase
    end
  end

  // Read FSM: the next address is read on each handshake so bytes flow every cycle.
  always_comb begin
    state_nxt     = state;
    lq_pop        = 1'b0;
    ram_re        = 1'b0;
    ram_ra        = rd_ptr[ADDR_W-1:0];
    rd_ptr_nxt    = rd_ptr;
    remaining_nxt = remaining;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    case (state)
      RD_IDLE: begin
        if (!lq_empty) begin
          lq_pop        = 1'b1;
          ram_re        = 1'b1;
          remaining_nxt = lq_head;
          state_nxt     = RD_FETCH;
        end
      end
      RD_FETCH: begin
        out_valid_nxt = 1'b1;
        out_last_nxt  = remaining == LEN_W'(1);
        state_nxt     = RD_STREAM;
      end
      RD_STREAM: begin
        if (out_ready) begin
          rd_ptr_nxt    = rd_ptr_inc;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            state_nxt     = RD_IDLE;
          end else begin
            ram_re       = 1'b1;
            ram_ra       = rd_ptr_inc[ADDR_W-1:0];
            out_last_nxt = remaining == LEN_W'(2);
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RD_IDLE;
      rd_ptr    <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      buf_level <= '0;
    end else begin
      state     <= state_nxt;
      rd_ptr    <= rd_ptr_nxt;
      remaining <= remaining_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      buf_level <= commit_ptr_nxt - rd_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_udp_rx_buffer_ctrl.sv
// Directed self-checking bench for udp_rx_buffer_ctrl.
module tb_udp_rx_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_abort, out_ready;
  logic [7:0]  out_data, s_out_data;
  logic        out_valid, out_last, s_out_valid, s_out_last;
  logic [15:0] frames_ok, frames_dropped, s_frames_ok, s_frames_dropped;
  logic [11:0] buf_level;
  logic [4:0]  s_buf_level;

  int checks = 0;
  int errors = 0;
  int s_valid_cnt = 0;
  logic [7:0] byte_q[$];
  logic       last_q[$];
  logic [7:0] exp_b[$];
  logic       exp_l[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always #5 clk = ~clk;

  udp_rx_buffer_ctrl dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_abort(in_abort), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frames_ok(frames_ok), .frames_dropped(frames_dropped), .buf_level(buf_level)
  );

  udp_rx_buffer_ctrl #(.ADDR_W(4)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_abort(in_abort), .out_data(s_out_data),
    .out_valid(s_out_valid), .out_last(s_out_last), .out_ready(out_ready),
    .frames_ok(s_frames_ok), .frames_dropped(s_frames_dropped), .buf_level(s_buf_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture handshakes and check that a stalled output holds steady.
  always @(posedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        byte_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    if (s_out_valid) s_valid_cnt++;
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    byte_q.delete(); last_q.delete(); exp_b.delete(); exp_l.delete();
    s_valid_cnt = 0;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic last);
    exp_b.push_back(d);
    exp_l.push_back(last);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, 32'(byte_q.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < byte_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(byte_q[i]), 32'(exp_b[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(exp_l[i]));
    end
    byte_q.delete(); last_q.delete(); exp_b.delete(); exp_l.delete();
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    in_abort = 1'b0; out_ready = 1'b0;
    cycles(3);
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ok", 32'(frames_ok), 32'd0);
    chk("rst_drop", 32'(frames_dropped), 32'd0);
    chk("rst_level", 32'(buf_level), 32'd0);

    // Single frame, consumer always ready, with first-byte latency check.
    out_ready = 1'b1;
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b1);
    cycles(1);
    chk("lat_valid_c1", 32'(out_valid), 32'd0);
    cycles(1);
    chk("lat_valid_c2", 32'(out_valid), 32'd1);
    chk("lat_data_c2", 32'(out_data), 32'hDE);
    cycles(8);
    expect_byte(8'hDE, 0); expect_byte(8'hAD, 0); expect_byte(8'hBE, 0); expect_byte(8'hEF, 1);
    cmp_stream("t1");
    chk("t1_ok", 32'(frames_ok), 32'd1);
    chk("t1_level", 32'(buf_level), 32'd0);

    // Aborted partial frame followed by a good frame.
    do_reset();
    out_ready = 1'b1;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    in_abort = 1'b1; cycles(1); in_abort = 1'b0;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
    cycles(10);
    expect_byte(8'h01, 0); expect_byte(8'h02, 0); expect_byte(8'h03, 0); expect_byte(8'h04, 1);
    cmp_stream("t2");
    chk("t2_drop", 32'(frames_dropped), 32'd1);
    chk("t2_ok", 32'(frames_ok), 32'd1);

    // Five frames while stalled: length FIFO admits four.
    do_reset();
    out_ready = 1'b0;
    for (int f = 0; f < 5; f++)
      for (int j = 0; j < 4; j++)
        send_byte(8'(f * 16 + j), j == 3);
    cycles(4);
    chk("t3_ok", 32'(frames_ok), 32'd4);
    chk("t3_drop", 32'(frames_dropped), 32'd1);
    chk("t3_level", 32'(buf_level), 32'd16);
    chk("t3_stall_valid", 32'(out_valid), 32'd1);
    chk("t3_stall_data", 32'(out_data), 32'h00);
    out_ready = 1'b1;
    cycles(40);
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < 4; j++)
        expect_byte(8'(f * 16 + j), j == 3);
    cmp_stream("t3");
    chk("t3_level_end", 32'(buf_level), 32'd0);

    // 20-byte frame into a 16-byte buffer is rolled back.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1), i == 19);
    cycles(4);
    chk("t4_drop", 32'(s_frames_dropped), 32'd1);
    chk("t4_ok", 32'(s_frames_ok), 32'd0);
    chk("t4_level", 32'(s_buf_level), 32'd0);
    chk("t4_no_valid", 32'(s_valid_cnt), 32'd0);

    // Toggling ready: data holds while stalled, order and last preserved.
    do_reset();
    out_ready = 1'b0;
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b1);
    cycles(5);
    chk("t5_stall_data", 32'(out_data), 32'hAA);
    for (int i = 0; i < 20; i++) begin
      out_ready = ~out_ready;
      cycles(1);
    end
    out_ready = 1'b0;
    expect_byte(8'hAA, 0); expect_byte(8'hBB, 0); expect_byte(8'hCC, 0); expect_byte(8'hDD, 1);
    cmp_stream("t5");

    // Reset while streaming, then a clean frame.
    do_reset();
    out_ready = 1'b0;
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b1);
    cycles(4);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ok", 32'(frames_ok), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    byte_q.delete(); last_q.delete();
    cycles(2);
    reset = 1'b0;
    cycles(5);
    chk("t6_post_valid", 32'(out_valid), 32'd0);
    chk("t6_post_level", 32'(buf_level), 32'd0);
    out_ready = 1'b1;
    send_byte(8'h9A, 1'b0); send_byte(8'hBC, 1'b0);
    send_byte(8'hDE, 1'b0); send_byte(8'hF0, 1'b1);
    cycles(10);
    expect_byte(8'h9A, 0); expect_byte(8'hBC, 0); expect_byte(8'hDE, 0); expect_byte(8'hF0, 1);
    cmp_stream("t6");
    chk("t6_ok", 32'(frames_ok), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
